serial_adder: RTL and testbench

//   Parametrised multi-cycle adder/subtractor built on a DIGIT-bit adder slice.

---
 rtl/serial_adder_if.sv | 27 ++
 rtl/serial_adder.sv | 101 ++++++++++
 tb/tb_serial_adder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The master drives operands and accepts results; the slave is the adder.
interface serial_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit result over WIDTH/DIGIT cycles, LS digit first.
// Subtraction reuses the adder as a + ~b + ~cin, so cout=1 means "no borrow".
module serial_adder #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   generate
      if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
         $error("serial_adder: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)", WIDTH, DIGIT);
      end
   endgenerate

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] areg;
   logic [WIDTH-1:0] breg;
   logic [WIDTH-1:0] sreg;
   logic             coutreg;
   logic             ovfreg;

   logic [DIGIT-1:0] adig;
   logic [DIGIT-1:0] bdig;
   logic [DIGIT:0]   dsum;
   logic             msbcarry;
   logic             lastdig;
   logic [WIDTH-1:0] snext;

   // One digit slice per cycle; the carry into the top bit of the slice is
   // recovered from the sum bit so the last digit can report signed overflow.
   always_comb begin
      adig     = areg[DIGIT-1:0];
      bdig     = breg[DIGIT-1:0];
      dsum     = {1'b0, adig} + {1'b0, bdig} + {{DIGIT{1'b0}}, carry};
      msbcarry = dsum[DIGIT-1] ^ adig[DIGIT-1] ^ bdig[DIGIT-1];
      snext    = WIDTH'({dsum[DIGIT-1:0], sreg} >> DIGIT);
      lastdig  = (cnt == CW'(NDIG - 1));
   end

   assign bus.in_ready  = rst_n && (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.sum       = sreg;
   assign bus.cout      = coutreg;
   assign bus.ovf       = ovfreg;

   // Operands are captured only on the accept edge and then consumed from the
   // shift registers, so later changes on the input bus cannot leak in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         carry   <= 1'b0;
         areg    <= '0;
         breg    <= '0;
         sreg    <= '0;
         coutreg <= 1'b0;
         ovfreg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  areg  <= bus.a;
                  breg  <= bus.sub ? ~bus.b : bus.b;
                  carry <= bus.sub ? ~bus.cin : bus.cin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               areg  <= areg >> DIGIT;
               breg  <= breg >> DIGIT;
               sreg  <= snext;
               carry <= dsum[DIGIT];
               cnt   <= cnt + 1'b1;
               if (lastdig) begin
                  coutreg <= dsum[DIGIT];
                  ovfreg  <= msbcarry ^ dsum[DIGIT];
                  state   <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8, DIGIT=2): directed vectors with
// literal expectations plus an arithmetic reference model checked every cycle.
module tb_serial_adder;
   localparam int W    = 8;
   localparam int D    = 2;
   localparam int NDIG = W / D;

   logic clk;
   logic rst_n;
   int   vectors = 0;
   int   errors  = 0;
   int   cyc     = 0;
   bit   randReady = 0;

   logic [9:0] expq[$];
   int         accq[$];
   bit         seen = 0;

   serial_adder_if #(.WIDTH(W)) bus ();

   serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic sub);
      int ua, ub, sa, sb, r, sr;
      logic [7:0] s;
      logic co, ov;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sub) begin
         r  = ua - ub - int'(cin);
         sr = sa - sb - int'(cin);
         co = (r >= 0);
      end else begin
         r  = ua + ub + int'(cin);
         sr = sa + sb + int'(cin);
         co = (r > 255);
      end
      s  = 8'(r & 255);
      ov = (sr > 127) || (sr < -128);
      return {ov, co, s};
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Every cycle: a visible result must match the oldest accepted operation.
   always @(negedge clk) begin
      if (!rst_n) begin
         expq.delete();
         accq.delete();
         seen = 0;
      end else begin
         if (bus.out_valid) begin
            if (expq.size() == 0) begin
               vectors++;
               errors++;
               $display("[TB] FAIL spurious_result: out_valid=1 with no accepted operation (cycle %0d)", cyc);
            end else begin
               if (!seen) begin
                  seen = 1;
                  checkValue("latency", 32'(cyc - accq[0]), 32'(NDIG));
               end
               checkValue("model_result", {22'd0, bus.ovf, bus.cout, bus.sum}, {22'd0, expq[0]});
               checkValue("no_overlap_in_ready", {31'd0, bus.in_ready}, 32'd0);
               if (bus.out_ready) begin
                  void'(expq.pop_front());
                  void'(accq.pop_front());
                  seen = 0;
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            expq.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
            accq.push_back(cyc + 1);
         end
      end
   end

   // Random consumer stalls, only while the sweep is running.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (randReady) bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic sub);
      bit ok;
      ok = 0;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.sub      = sub;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (!ok) begin
         vectors++;
         errors++;
         $display("[TB] FAIL accept_timeout: in_ready never rose for a=%0h b=%0h", a, b);
      end
   endtask

   task automatic checkOutput(input string name, input logic [7:0] es,
                              input logic ec, input logic eo);
      bit found;
      found = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            found = 1;
            break;
         end
      end
      if (!found) begin
         vectors++;
         errors++;
         $display("[TB] FAIL %s_timeout: out_valid never rose", name);
      end else begin
         checkValue({name, "_sum"},  {24'd0, bus.sum}, {24'd0, es});
         checkValue({name, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
         checkValue({name, "_ovf"},  {31'd0, bus.ovf}, {31'd0, eo});
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkValue("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkValue("reset_in_ready",  {31'd0, bus.in_ready}, 32'd0);
      checkValue("reset_sum",       {24'd0, bus.sum}, 32'd0);
      checkValue("reset_flags",     {30'd0, bus.cout, bus.ovf}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkValue("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

      $display("[TB] wrap-around add");
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
      checkOutput("ff_plus_01", 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      checkValue("ready_after_consume", {31'd0, bus.in_ready}, 32'd1);
      checkValue("valid_after_consume", {31'd0, bus.out_valid}, 32'd0);

      $display("[TB] subtract and overflow");
      @(posedge clk);
      #1;
      applyStimulus(8'h10, 8'h20, 1'b0, 1'b1);
      checkOutput("sub_10_20", 8'hF0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0);
      checkOutput("add_7f_01", 8'h80, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      applyStimulus(8'h80, 8'h01, 1'b0, 1'b1);
      checkOutput("sub_80_01", 8'h7F, 1'b1, 1'b1);

      $display("[TB] backpressure");
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      applyStimulus(8'h3C, 8'h15, 1'b1, 1'b0);
      checkOutput("bp_first", 8'h52, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.a        = 8'hAA;
      bus.b        = 8'h55;
      bus.sub      = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checkValue("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
         checkValue("bp_held_sum", {24'd0, bus.sum}, 32'h52);
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkValue("bp_consumed", {31'd0, bus.out_valid}, 32'd0);

      $display("[TB] reset mid-operation");
      @(posedge clk);
      #1;
      applyStimulus(8'h55, 8'h66, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkValue("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkValue("abort_sum",       {24'd0, bus.sum}, 32'd0);
      checkValue("abort_in_ready",  {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(8'h03, 8'h04, 1'b1, 1'b0);
      checkOutput("after_reset", 8'h08, 1'b0, 1'b0);

      $display("[TB] random sweep with stalls");
      @(posedge clk);
      #1;
      randReady = 1;
      for (int n = 0; n < 400; n++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         if (n % 50 == 0) ra = 8'h80;
         if (n % 50 == 1) rb = 8'hFF;
         applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge clk);
      randReady = 0;
      checkValue("drain_queue", 32'(expq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
